// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge feeders: default geometry,
// feeder state encoding and the lane slicing helper.
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LANES      = 4;
    localparam int DEFAULT_DEPTH      = 4;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } feeder_state_e;

    // Bit offset of a lane inside a packed LANES*width vector.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Feeder bus: upstream valid/ready tile input plus the lock-step skewed
// output into the array edge (no output backpressure).
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = systolic_pkg::DEFAULT_DATA_WIDTH,
    parameter int LANES      = systolic_pkg::DEFAULT_LANES
);

    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_last;
    logic                        out_valid;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic                        done;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_valid, out_data, done
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_valid, out_data, done
    );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers one tile of LANES-wide vectors, then streams it with lane i delayed
// by i cycles and zero padding outside the wavefront.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LANES      = DEFAULT_LANES,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input logic                   clk,
    input logic                   rst,
    systolic_skew_feeder_if.slave feed
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int T_W   = $clog2(DEPTH + LANES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    feeder_state_e   state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [T_W-1:0]   t_q, t_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             accept;

    logic [LANES*DATA_WIDTH-1:0] out_data_w;

    assign feed.in_ready  = (state_q == LOAD) && !rst;
    assign accept         = feed.in_valid && feed.in_ready;
    assign feed.out_valid = out_valid_q;
    assign feed.out_data  = out_data_w;
    assign feed.done      = done_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            count_q     <= '0;
            n_q         <= '0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            n_q         <= n_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        n_d         = n_q;
        t_d         = t_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    // in_last on the DEPTH-th beat is still one transition.
                    if (feed.in_last || (int'(count_q) == DEPTH - 1)) begin
                        state_d = STREAM;
                        n_d     = count_q + 1'b1;
                        t_d     = '0;
                    end
                end
            end
            STREAM: begin
                out_valid_d = 1'b1;
                t_d         = t_q + 1'b1;
                if (int'(t_q) == int'(n_q) + LANES - 2) begin
                    done_d  = 1'b1;
                    state_d = LOAD;
                    count_d = '0;
                end
            end
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] buf_q [DEPTH];
        logic [DATA_WIDTH-1:0] lane_q;
        logic                  hit;
        logic [IDX_W-1:0]      rd_idx;

        // Lane i reads vector t-i while that index lies inside the tile.
        always_comb begin
            hit    = 1'b0;
            rd_idx = '0;
            if ((state_q == STREAM) && (int'(t_q) >= i) &&
                (int'(t_q) - i < int'(n_q))) begin
                hit    = 1'b1;
                rd_idx = IDX_W'(int'(t_q) - i);
            end
        end

        // NOTE: the buffer is deliberately left out of reset; it is always
        // written before it is read, so only the output register is cleared.
        always_ff @(posedge clk) begin
            if (accept) begin
                buf_q[IDX_W'(count_q)] <= feed.in_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end
            if (rst) begin
                lane_q <= '0;
            end else if (hit) begin
                lane_q <= buf_q[rd_idx];
            end else begin
                lane_q <= '0;
            end
        end

        assign out_data_w[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = lane_q;
    end

endmodule
